// File: rtl/pll_reset_sequencer.sv
// PLL supervisor and staged reset sequencer, clocked from the PLL reference.
// Pulses the PLL RESET pin, waits for LOCK (with timeout and retry), requires
// lock to hold for a stable window, then releases domain resets in index order.
// Any lock loss after release has begun forces a full re-acquisition.
//
// Ports:
//   clk          reference oscillator (not the PLL output)
//   reset        synchronous, active-high
//   pll_lock     PLL LOCK, asynchronous to clk
//   pll_reset    PLL RESET pin, active-high
//   stage_reset  active-high domain resets, bit 0 released first
//   ready        high while locked and all stages released
//   retry_count  saturating count of PLL reset re-issues
//   lock_lost    sticky flag, lock dropped after release began
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 270000,
  parameter int unsigned STABLE_CYCLES = 2700,
  parameter int unsigned STAGE_GAP     = 16,
  parameter int unsigned STAGES        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [STAGES-1:0] stage_reset,
  output logic              ready,
  output logic [3:0]        retry_count,
  output logic              lock_lost
);

  localparam int unsigned RELEASE_CYCLES = STAGES * STAGE_GAP;
  localparam int unsigned MAX_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B  = (STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES : RELEASE_CYCLES;
  localparam int unsigned MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW     = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [1:0]        sync_q;
  logic              lock_s;
  logic              rst_hold;
  logic              retry_inc;
  logic [STAGES-1:0] stage_n;
  logic [3:0]        retry_n;
  logic              lost_n;

  assign lock_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous LOCK input
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], pll_lock};
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_PLLRST;
      cnt         <= '0;
      rst_hold    <= 1'b1;
      pll_reset   <= 1'b1;
      stage_reset <= '1;
      ready       <= 1'b0;
      retry_count <= 4'd0;
      lock_lost   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rst_hold    <= 1'b0;
      pll_reset   <= (state_n == S_PLLRST);
      stage_reset <= stage_n;
      ready       <= (state_n == S_RUN);
      retry_count <= retry_n;
      lock_lost   <= lost_n;
    end
  end

  // Next-state, counter and output logic
  always_comb begin
    state_n   = state;
    stage_n   = stage_reset;
    lost_n    = lock_lost;
    retry_inc = 1'b0;
    retry_n   = retry_count;
    cnt_n     = '0;

    case (state)
      S_PLLRST: begin
        if (cnt == CW'(RST_CYCLES - 1)) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (lock_s) begin
          state_n = S_STABLE;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          state_n   = S_PLLRST;
          retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        // A drop during the stable window is an acquisition glitch only
        if (!lock_s) begin
          state_n = S_WAIT;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          state_n    = S_RELEASE;
          stage_n[0] = 1'b0;
        end
      end
      S_RELEASE: begin
        if (!lock_s) begin
          state_n   = S_PLLRST;
          lost_n    = 1'b1;
          retry_inc = 1'b1;
        end else begin
          for (int unsigned k = 1; k < STAGES; k++) begin
            if (cnt == CW'(k * STAGE_GAP - 1)) stage_n[k] = 1'b0;
          end
          if (cnt == CW'(RELEASE_CYCLES - 1)) state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_n   = S_PLLRST;
          lost_n    = 1'b1;
          retry_inc = 1'b1;
        end
      end
      default: state_n = S_PLLRST;
    endcase

    if (state_n == S_PLLRST) stage_n = '1;

    if (retry_inc && (retry_count != 4'hF)) retry_n = retry_count + 4'd1;

    // The edge leaving reset does not count toward the first PLL reset pulse
    if ((state_n == state) && !rst_hold) cnt_n = cnt + CW'(1);
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
// Edge 0 is the first rising edge with reset low; outputs are sampled 1 time
// unit after each rising edge and compared against hand-computed values packed
// as {pll_reset, stage_reset[1:0], ready, lock_lost, retry_count[3:0]}.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       pll_reset;
  logic [1:0] stage_reset;
  logic       ready;
  logic [3:0] retry_count;
  logic       lock_lost;

  logic [8:0] obs;
  assign obs = {pll_reset, stage_reset, ready, lock_lost, retry_count};

  int vectors = 0;
  int errors  = 0;
  int edge_no = -1;

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .STAGE_GAP    (3),
    .STAGES       (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .stage_reset(stage_reset),
    .ready      (ready),
    .retry_count(retry_count),
    .lock_lost  (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_to(input int n);
    while (edge_no < n) begin
      @(posedge clk);
      #1;
      edge_no++;
    end
  endtask

  task automatic do_reset(input logic lock);
    reset    = 1'b1;
    pll_lock = lock;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    edge_no = -1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    vectors++;
    if (obs !== {1'b1, 2'b11, 1'b0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL reset_values obs=%b exp=%b", obs, {1'b1, 2'b11, 1'b0, 1'b0, 4'd0});
    end
  endtask

  task automatic test_clean_bringup();
    do_reset(1'b0);
    run_to(3);
    vectors++;
    if (obs !== 9'b1_11_0_0_0000) begin errors++; $display("FAIL clean_e3 obs=%b exp=%b", obs, 9'b1_11_0_0_0000); end
    run_to(4);
    vectors++;
    if (obs !== 9'b0_11_0_0_0000) begin errors++; $display("FAIL clean_e4 obs=%b exp=%b", obs, 9'b0_11_0_0_0000); end
    run_to(10);
    pll_lock = 1'b1;
    run_to(20);
    vectors++;
    if (obs !== 9'b0_11_0_0_0000) begin errors++; $display("FAIL clean_e20 obs=%b exp=%b", obs, 9'b0_11_0_0_0000); end
    run_to(21);
    vectors++;
    if (obs !== 9'b0_10_0_0_0000) begin errors++; $display("FAIL clean_e21 obs=%b exp=%b", obs, 9'b0_10_0_0_0000); end
    run_to(23);
    vectors++;
    if (obs !== 9'b0_10_0_0_0000) begin errors++; $display("FAIL clean_e23 obs=%b exp=%b", obs, 9'b0_10_0_0_0000); end
    run_to(24);
    vectors++;
    if (obs !== 9'b0_00_0_0_0000) begin errors++; $display("FAIL clean_e24 obs=%b exp=%b", obs, 9'b0_00_0_0_0000); end
    run_to(26);
    vectors++;
    if (obs !== 9'b0_00_0_0_0000) begin errors++; $display("FAIL clean_e26 obs=%b exp=%b", obs, 9'b0_00_0_0_0000); end
    run_to(27);
    vectors++;
    if (obs !== 9'b0_00_1_0_0000) begin errors++; $display("FAIL clean_e27 obs=%b exp=%b", obs, 9'b0_00_1_0_0000); end
  endtask

  // Continues from RUN reached by test_clean_bringup
  task automatic test_lock_loss_run();
    run_to(30);
    pll_lock = 1'b0;
    run_to(31);
    pll_lock = 1'b1;
    run_to(32);
    vectors++;
    if (obs !== 9'b0_00_1_0_0000) begin errors++; $display("FAIL loss_run_e32 obs=%b exp=%b", obs, 9'b0_00_1_0_0000); end
    run_to(33);
    vectors++;
    if (obs !== 9'b1_11_0_1_0001) begin errors++; $display("FAIL loss_run_e33 obs=%b exp=%b", obs, 9'b1_11_0_1_0001); end
    run_to(36);
    vectors++;
    if (obs !== 9'b1_11_0_1_0001) begin errors++; $display("FAIL loss_run_e36 obs=%b exp=%b", obs, 9'b1_11_0_1_0001); end
    run_to(37);
    vectors++;
    if (obs !== 9'b0_11_0_1_0001) begin errors++; $display("FAIL loss_run_e37 obs=%b exp=%b", obs, 9'b0_11_0_1_0001); end
    run_to(46);
    vectors++;
    if (obs !== 9'b0_10_0_1_0001) begin errors++; $display("FAIL loss_run_e46 obs=%b exp=%b", obs, 9'b0_10_0_1_0001); end
    run_to(49);
    vectors++;
    if (obs !== 9'b0_00_0_1_0001) begin errors++; $display("FAIL loss_run_e49 obs=%b exp=%b", obs, 9'b0_00_0_1_0001); end
    run_to(52);
    vectors++;
    if (obs !== 9'b0_00_1_1_0001) begin errors++; $display("FAIL loss_run_e52 obs=%b exp=%b", obs, 9'b0_00_1_1_0001); end
  endtask

  // Continues from RUN with lock_lost=1 and retry_count=1
  task automatic test_reset_mid();
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== 9'b1_11_0_0_0000) begin errors++; $display("FAIL rstmid_values obs=%b exp=%b", obs, 9'b1_11_0_0_0000); end
    reset   = 1'b0;
    edge_no = -1;
    run_to(3);
    vectors++;
    if (obs !== 9'b1_11_0_0_0000) begin errors++; $display("FAIL rstmid_e3 obs=%b exp=%b", obs, 9'b1_11_0_0_0000); end
    run_to(4);
    vectors++;
    if (obs !== 9'b0_11_0_0_0000) begin errors++; $display("FAIL rstmid_e4 obs=%b exp=%b", obs, 9'b0_11_0_0_0000); end
    run_to(13);
    vectors++;
    if (obs !== 9'b0_10_0_0_0000) begin errors++; $display("FAIL rstmid_e13 obs=%b exp=%b", obs, 9'b0_10_0_0_0000); end
    run_to(16);
    vectors++;
    if (obs !== 9'b0_00_0_0_0000) begin errors++; $display("FAIL rstmid_e16 obs=%b exp=%b", obs, 9'b0_00_0_0_0000); end
    run_to(19);
    vectors++;
    if (obs !== 9'b0_00_1_0_0000) begin errors++; $display("FAIL rstmid_e19 obs=%b exp=%b", obs, 9'b0_00_1_0_0000); end
  endtask

  task automatic test_no_lock();
    do_reset(1'b0);
    run_to(4);
    vectors++;
    if (obs !== 9'b0_11_0_0_0000) begin errors++; $display("FAIL nolock_e4 obs=%b exp=%b", obs, 9'b0_11_0_0_0000); end
    run_to(23);
    vectors++;
    if (obs !== 9'b0_11_0_0_0000) begin errors++; $display("FAIL nolock_e23 obs=%b exp=%b", obs, 9'b0_11_0_0_0000); end
    run_to(24);
    vectors++;
    if (obs !== 9'b1_11_0_0_0001) begin errors++; $display("FAIL nolock_e24 obs=%b exp=%b", obs, 9'b1_11_0_0_0001); end
    run_to(28);
    vectors++;
    if (obs !== 9'b0_11_0_0_0001) begin errors++; $display("FAIL nolock_e28 obs=%b exp=%b", obs, 9'b0_11_0_0_0001); end
    run_to(48);
    vectors++;
    if (obs !== 9'b1_11_0_0_0010) begin errors++; $display("FAIL nolock_e48 obs=%b exp=%b", obs, 9'b1_11_0_0_0010); end
    run_to(359);
    vectors++;
    if (obs !== 9'b0_11_0_0_1110) begin errors++; $display("FAIL nolock_e359 obs=%b exp=%b", obs, 9'b0_11_0_0_1110); end
    run_to(360);
    vectors++;
    if (obs !== 9'b1_11_0_0_1111) begin errors++; $display("FAIL nolock_e360 obs=%b exp=%b", obs, 9'b1_11_0_0_1111); end
    run_to(384);
    vectors++;
    if (obs !== 9'b1_11_0_0_1111) begin errors++; $display("FAIL nolock_sat_e384 obs=%b exp=%b", obs, 9'b1_11_0_0_1111); end
  endtask

  task automatic test_glitch();
    do_reset(1'b0);
    run_to(10);
    pll_lock = 1'b1;
    run_to(16);
    pll_lock = 1'b0;
    run_to(18);
    pll_lock = 1'b1;
    run_to(21);
    vectors++;
    if (obs !== 9'b0_11_0_0_0000) begin errors++; $display("FAIL glitch_e21 obs=%b exp=%b", obs, 9'b0_11_0_0_0000); end
    run_to(28);
    vectors++;
    if (obs !== 9'b0_11_0_0_0000) begin errors++; $display("FAIL glitch_e28 obs=%b exp=%b", obs, 9'b0_11_0_0_0000); end
    run_to(29);
    vectors++;
    if (obs !== 9'b0_10_0_0_0000) begin errors++; $display("FAIL glitch_e29 obs=%b exp=%b", obs, 9'b0_10_0_0_0000); end
    run_to(32);
    vectors++;
    if (obs !== 9'b0_00_0_0_0000) begin errors++; $display("FAIL glitch_e32 obs=%b exp=%b", obs, 9'b0_00_0_0_0000); end
    run_to(35);
    vectors++;
    if (obs !== 9'b0_00_1_0_0000) begin errors++; $display("FAIL glitch_e35 obs=%b exp=%b", obs, 9'b0_00_1_0_0000); end
  endtask

  task automatic test_loss_release();
    do_reset(1'b0);
    run_to(10);
    pll_lock = 1'b1;
    run_to(21);
    vectors++;
    if (obs !== 9'b0_10_0_0_0000) begin errors++; $display("FAIL relloss_e21 obs=%b exp=%b", obs, 9'b0_10_0_0_0000); end
    pll_lock = 1'b0;
    run_to(22);
    vectors++;
    if (obs !== 9'b0_10_0_0_0000) begin errors++; $display("FAIL relloss_e22 obs=%b exp=%b", obs, 9'b0_10_0_0_0000); end
    run_to(23);
    vectors++;
    if (obs !== 9'b0_10_0_0_0000) begin errors++; $display("FAIL relloss_e23 obs=%b exp=%b", obs, 9'b0_10_0_0_0000); end
    run_to(24);
    vectors++;
    if (obs !== 9'b1_11_0_1_0001) begin errors++; $display("FAIL relloss_e24 obs=%b exp=%b", obs, 9'b1_11_0_1_0001); end
    run_to(30);
    vectors++;
    if (obs !== 9'b0_11_0_1_0001) begin errors++; $display("FAIL relloss_e30 obs=%b exp=%b", obs, 9'b0_11_0_1_0001); end
  endtask

  initial begin
    reset    = 1'b1;
    pll_lock = 1'b0;
    test_reset();
    test_clean_bringup();
    test_lock_loss_run();
    test_reset_mid();
    test_no_lock();
    test_glitch();
    test_loss_release();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
